spi_cntrl: RTL

SPI_CNTRL -- requirements
Module: spi_cntrl

---
 rtl/spi_cntrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/spi_cntrl.sv
// SPI mode-0 master that moves one byte per start request, with optional chip-select
// hold so that consecutive bytes form one framed burst.
module spi_cntrl #(
  parameter int CLK_FREQUENCY  = 100_000_000,
  parameter int SCLK_FREQUENCY = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_to_send,
  input  logic       hold_cs,
  output logic [7:0] data_received,
  output logic       busy,
  output logic       done,
  output logic       SPI_SCLK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO,
  output logic       SPI_CS,
  output logic [2:0] state_dbg
);

  localparam int HALF = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
  localparam int CW   = (HALF < 1) ? 1 : $clog2(HALF + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((HALF < 1) ? 0 : HALF - 1);

  if (HALF < 1) begin : g_cfg_check
    $error("spi_cntrl: SCLK_FREQUENCY too high for CLK_FREQUENCY (HALF < 1)");
  end

  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, TRAIL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    drx_q, drx_d;
  logic          hold_q, hold_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Handshake: start is a level request sampled only in IDLE and HOLD; the byte is
  // accepted on the clock edge where start is seen there, and busy/CS reflect that
  // acceptance on the next cycle. Requests in any other state are dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    drx_d   = drx_q;
    hold_d  = hold_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          tx_d    = data_to_send;
          hold_d  = hold_cs;
          bit_d   = 3'd0;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (cnt_q == HALF_LAST) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], SPI_MISO};
          cnt_d   = '0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (cnt_q == HALF_LAST) begin
          sclk_d = 1'b0;
          cnt_d  = '0;
          if (bit_q != 3'd7) begin
            tx_d    = {tx_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            state_d = LOW;
          end else begin
            // rx_q already holds all 8 bits: the last one was taken on the final rising edge
            drx_d  = rx_q;
            done_d = 1'b1;
            if (hold_q) begin
              busy_d  = 1'b0;
              state_d = HOLD;
            end else begin
              cs_d    = 1'b1;
              state_d = TRAIL;
            end
          end
        end
      end
      HOLD: begin
        cnt_d = '0;
        if (start) begin
          tx_d    = data_to_send;
          hold_d  = hold_cs;
          bit_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = LOW;
        end else if (!hold_cs) begin
          cs_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = TRAIL;
        end
      end
      TRAIL: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      tx_q    <= 8'h00;
      rx_q    <= 8'h00;
      drx_q   <= 8'h00;
      hold_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      drx_q   <= drx_d;
      hold_q  <= hold_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_received = drx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign SPI_SCLK      = sclk_q;
  assign SPI_MOSI      = tx_q[7];
  assign SPI_CS        = cs_q;
  assign state_dbg     = state_q;

endmodule
